// File: rtl/sd_sector_buffer.sv
// sd_sector_buffer
// One-sector (512 byte) staging buffer in front of an SD card controller.
// The host fills or drains the buffer while idle, then asks for a single
// sector read or write. The FSM hands the request to the controller, streams
// bytes between the RAM and the controller, and reports done or error.
module sd_sector_buffer #(
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        host_rd_req,
   input  logic        host_wr_req,
   input  logic [25:0] host_sector,
   input  logic [8:0]  host_addr,
   input  logic        host_we,
   input  logic [7:0]  host_wdata,
   output logic [7:0]  host_rdata,
   output logic        host_busy,
   output logic        host_done,
   output logic        host_error,
   output logic        sd_op_code,
   output logic        sd_execute,
   output logic [25:0] sd_sector_address,
   output logic [7:0]  sd_outgoing_byte,
   input  logic [7:0]  sd_incoming_byte,
   input  logic        sd_finished_byte,
   input  logic        sd_finished_sector,
   input  logic        sd_busy
);

   localparam int         TW           = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [9:0] SECTOR_BYTES = 10'd512;

   typedef enum logic [2:0] {
      IDLE, WAIT_READY, ISSUE, XFER, DONE, ERR
   } state_t;

   state_t        state;
   logic [9:0]    count;
   logic [TW-1:0] timer;
   logic [7:0]    ram [512];

   logic          byte_ok;
   logic [9:0]    count_inc;
   logic          timer_expire;
   logic          ram_we;
   logic [8:0]    ram_waddr;
   logic [7:0]    ram_wdata;

   // Shared RAM write port: host writes while idle, captured card bytes
   // during a read transfer. The two never overlap because they are
   // qualified by different states.
   always_comb begin
      byte_ok   = (state == XFER) && sd_finished_byte && (count != SECTOR_BYTES);
      count_inc = count + 10'd1;
      // The timer is cleared on the strobe edge, so expiry is flagged one
      // count early to land exactly TIMEOUT_CYCLES after the strobe began.
      timer_expire = (int'(timer) + 2 >= TIMEOUT_CYCLES);
      ram_we    = 1'b0;
      ram_waddr = host_addr;
      ram_wdata = host_wdata;
      if (state == IDLE) begin
         ram_we = host_we;
      end else if (byte_ok && !sd_op_code) begin
         ram_we    = 1'b1;
         ram_waddr = count[8:0];
         ram_wdata = sd_incoming_byte;
      end
   end

   // Sector storage; contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (ram_we) ram[ram_waddr] <= ram_wdata;
   end

   // Registered read ports: host view and outgoing byte for write ops.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         host_rdata       <= 8'd0;
         sd_outgoing_byte <= 8'd0;
      end else begin
         host_rdata <= ram[host_addr];
         if (state == XFER && sd_op_code) sd_outgoing_byte <= ram[count[8:0]];
      end
   end

   // Request sequencing, byte counting, timeout and completion reporting.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state             <= IDLE;
         count             <= 10'd0;
         timer             <= '0;
         host_busy         <= 1'b0;
         host_done         <= 1'b0;
         host_error        <= 1'b0;
         sd_op_code        <= 1'b0;
         sd_execute        <= 1'b0;
         sd_sector_address <= 26'd0;
      end else begin
         host_done  <= 1'b0;
         sd_execute <= 1'b0;
         case (state)
            IDLE: begin
               // Read has priority when both requests show up together.
               if (host_rd_req || host_wr_req) begin
                  sd_sector_address <= host_sector;
                  sd_op_code        <= !host_rd_req;
                  host_error        <= 1'b0;
                  host_busy         <= 1'b1;
                  state             <= WAIT_READY;
               end
            end
            WAIT_READY: begin
               if (!sd_busy) begin
                  sd_execute <= 1'b1;
                  state      <= ISSUE;
               end
            end
            ISSUE: begin
               count <= 10'd0;
               timer <= '0;
               state <= XFER;
            end
            XFER: begin
               if (sd_finished_byte && count == SECTOR_BYTES) begin
                  // Overrun: controller delivered more than one sector.
                  host_done  <= 1'b1;
                  host_error <= 1'b1;
                  host_busy  <= 1'b0;
                  state      <= ERR;
               end else begin
                  if (sd_finished_byte) begin
                     count <= count_inc;
                     timer <= '0;
                  end else if (!timer_expire) begin
                     timer <= timer + TW'(1);
                  end
                  if (sd_finished_sector) begin
                     host_done <= 1'b1;
                     host_busy <= 1'b0;
                     if ((sd_finished_byte ? count_inc : count) == SECTOR_BYTES) begin
                        state <= DONE;
                     end else begin
                        host_error <= 1'b1;
                        state      <= ERR;
                     end
                  end else if (!sd_finished_byte && timer_expire) begin
                     host_done  <= 1'b1;
                     host_error <= 1'b1;
                     host_busy  <= 1'b0;
                     state      <= ERR;
                  end
               end
            end
            DONE:    state <= IDLE;
            ERR:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sd_sector_buffer.sv
// Bench for sd_sector_buffer: a simple controller model drives byte and
// sector strobes; a byte queue holds expected data for both directions.
module tb_sd_sector_buffer;

   localparam int TO = 50;
   localparam int M_WR_CHECK = 0;
   localparam int M_RD_PUSH  = 1;
   localparam int M_RD_QUIET = 2;
   localparam int M_WR_QUIET = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        host_rd_req = 1'b0;
   logic        host_wr_req = 1'b0;
   logic [25:0] host_sector = '0;
   logic [8:0]  host_addr = '0;
   logic        host_we = 1'b0;
   logic [7:0]  host_wdata = '0;
   logic [7:0]  host_rdata;
   logic        host_busy;
   logic        host_done;
   logic        host_error;
   logic        sd_op_code;
   logic        sd_execute;
   logic [25:0] sd_sector_address;
   logic [7:0]  sd_outgoing_byte;
   logic [7:0]  sd_incoming_byte = '0;
   logic        sd_finished_byte = 1'b0;
   logic        sd_finished_sector = 1'b0;
   logic        sd_busy = 1'b0;

   always #5 clk = ~clk;

   sd_sector_buffer #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .host_rd_req(host_rd_req), .host_wr_req(host_wr_req),
      .host_sector(host_sector), .host_addr(host_addr),
      .host_we(host_we), .host_wdata(host_wdata), .host_rdata(host_rdata),
      .host_busy(host_busy), .host_done(host_done), .host_error(host_error),
      .sd_op_code(sd_op_code), .sd_execute(sd_execute),
      .sd_sector_address(sd_sector_address), .sd_outgoing_byte(sd_outgoing_byte),
      .sd_incoming_byte(sd_incoming_byte), .sd_finished_byte(sd_finished_byte),
      .sd_finished_sector(sd_finished_sector), .sd_busy(sd_busy)
   );

   int         chk_cnt = 0;
   int         pass_cnt = 0;
   int         wr_seen = 0;
   logic [7:0] exp_q[$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Returns after the request edge (DUT now in WAIT_READY).
   task automatic host_req(input logic rd, input logic wr, input logic [25:0] sec);
      tick();
      host_rd_req = rd;
      host_wr_req = wr;
      host_sector = sec;
      tick();
      host_rd_req = 1'b0;
      host_wr_req = 1'b0;
   endtask

   task automatic wait_exec(output int cyc);
      cyc = -1;
      for (int c = 1; c <= 200; c++) begin
         tick();
         if (sd_execute === 1'b1) begin
            cyc = c;
            break;
         end
      end
   endtask

   // Controller model: one byte strobe every other cycle, starting from XFER.
   task automatic run_bytes(input int n, input int mode, input logic [7:0] seed);
      logic [7:0] d;
      logic [7:0] e;
      for (int i = 0; i < n; i++) begin
         tick();
         d = i[7:0] + seed;
         sd_incoming_byte = d;
         sd_finished_byte = 1'b1;
         if (mode == M_RD_PUSH) exp_q.push_back(d);
         if (mode == M_WR_CHECK) begin
            chk_cnt++;
            if (exp_q.size() == 0) begin
               $display("FAIL wr_byte[%0d] got %h, no expected byte left", i, sd_outgoing_byte);
            end else begin
               e = exp_q.pop_front();
               wr_seen++;
               if (sd_outgoing_byte !== e)
                  $display("FAIL wr_byte[%0d] got %h exp %h", i, sd_outgoing_byte, e);
               else pass_cnt++;
            end
         end
         tick();
         sd_finished_byte = 1'b0;
      end
   endtask

   task automatic readback_all(input string name);
      logic [7:0] e;
      for (int i = 0; i < 512; i++) begin
         tick();
         host_addr = i[8:0];
         tick();
         e = exp_q.pop_front();
         chk_cnt++;
         if (host_rdata !== e) $display("FAIL %s[%0d] got %h exp %h", name, i, host_rdata, e);
         else pass_cnt++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      chk_cnt++;
      if ({host_busy, host_done, host_error, sd_execute} !== 4'b0)
         $display("FAIL reset_flags got %b exp 0000", {host_busy, host_done, host_error, sd_execute});
      else pass_cnt++;
      chk_cnt++;
      if ({sd_op_code, sd_sector_address, sd_outgoing_byte, host_rdata} !== 43'd0)
         $display("FAIL reset_data got %h exp 0", {sd_op_code, sd_sector_address, sd_outgoing_byte, host_rdata});
      else pass_cnt++;
      rst_n = 1'b1;
   endtask

   task automatic test_read();
      int cyc;
      host_req(1'b1, 1'b0, 26'h12345);
      chk_cnt++;
      if (host_busy !== 1'b1) $display("FAIL rd_busy got %b exp 1", host_busy); else pass_cnt++;
      wait_exec(cyc);
      // Request edge already passed inside host_req: execute is one more edge.
      chk_cnt++;
      if (cyc !== 1) $display("FAIL rd_exec_latency got %0d exp 1", cyc); else pass_cnt++;
      chk_cnt++;
      if (sd_op_code !== 1'b0) $display("FAIL rd_opcode got %b exp 0", sd_op_code); else pass_cnt++;
      chk_cnt++;
      if (sd_sector_address !== 26'h12345)
         $display("FAIL rd_sector got %h exp 0012345", sd_sector_address);
      else pass_cnt++;
      tick();
      chk_cnt++;
      if (sd_execute !== 1'b0) $display("FAIL rd_exec_pulse got %b exp 0", sd_execute); else pass_cnt++;
      run_bytes(512, M_RD_PUSH, 8'h00);
      tick();
      sd_finished_sector = 1'b1;
      tick();
      sd_finished_sector = 1'b0;
      chk_cnt++;
      if ({host_done, host_error, host_busy} !== 3'b100)
         $display("FAIL rd_done got done/err/busy=%b exp 100", {host_done, host_error, host_busy});
      else pass_cnt++;
      tick();
      chk_cnt++;
      if (host_done !== 1'b0) $display("FAIL rd_done_pulse got %b exp 0", host_done); else pass_cnt++;
      readback_all("rd_ram");
   endtask

   task automatic test_write();
      int cyc;
      logic [7:0] v;
      wr_seen = 0;
      for (int i = 0; i < 512; i++) begin
         tick();
         v = i[7:0];
         host_we = 1'b1;
         host_addr = i[8:0];
         host_wdata = ~v;
         exp_q.push_back(~v);
      end
      tick();
      host_we = 1'b0;
      host_req(1'b0, 1'b1, 26'h3000001);
      wait_exec(cyc);
      chk_cnt++;
      if (cyc !== 1) $display("FAIL wr_exec_latency got %0d exp 1", cyc); else pass_cnt++;
      chk_cnt++;
      if (sd_op_code !== 1'b1) $display("FAIL wr_opcode got %b exp 1", sd_op_code); else pass_cnt++;
      tick();
      run_bytes(512, M_WR_CHECK, 8'h00);
      tick();
      sd_finished_sector = 1'b1;
      tick();
      sd_finished_sector = 1'b0;
      chk_cnt++;
      if (wr_seen !== 512 || exp_q.size() !== 0)
         $display("FAIL wr_count got %0d left %0d exp 512 left 0", wr_seen, exp_q.size());
      else pass_cnt++;
      chk_cnt++;
      if ({host_done, host_error, host_busy} !== 3'b100)
         $display("FAIL wr_done got done/err/busy=%b exp 100", {host_done, host_error, host_busy});
      else pass_cnt++;
   endtask

   task automatic test_short_sector();
      int cyc;
      host_req(1'b1, 1'b0, 26'h0000042);
      // Host tries to overwrite a byte the read never touches while busy.
      host_we = 1'b1;
      host_addr = 9'd400;
      host_wdata = 8'hC3;
      exp_q.push_back(8'h6F);  // left from the write fill: ~8'h90
      wait_exec(cyc);
      tick();
      run_bytes(300, M_RD_QUIET, 8'h00);
      host_we = 1'b0;
      tick();
      sd_finished_sector = 1'b1;
      tick();
      sd_finished_sector = 1'b0;
      chk_cnt++;
      if ({host_done, host_error, host_busy} !== 3'b110)
         $display("FAIL short_err got done/err/busy=%b exp 110", {host_done, host_error, host_busy});
      else pass_cnt++;
      tick();
      host_addr = 9'd400;
      tick();
      chk_cnt++;
      if (host_rdata !== exp_q[0]) $display("FAIL busy_we_ignored got %h exp %h", host_rdata, exp_q[0]);
      else pass_cnt++;
      void'(exp_q.pop_front());
   endtask

   task automatic test_timeout();
      int cyc;
      int lat;
      host_req(1'b1, 1'b0, 26'h0000099);
      wait_exec(cyc);
      lat = -1;
      for (int k = 1; k <= 200; k++) begin
         tick();
         if (host_error === 1'b1) begin
            lat = k;
            break;
         end
      end
      chk_cnt++;
      if (lat !== TO) $display("FAIL timeout_latency got %0d exp %0d", lat, TO); else pass_cnt++;
      chk_cnt++;
      if ({host_done, host_busy} !== 2'b10)
         $display("FAIL timeout_done got done/busy=%b exp 10", {host_done, host_busy});
      else pass_cnt++;
      repeat (5) tick();
      chk_cnt++;
      if ({host_error, host_done} !== 2'b10)
         $display("FAIL timeout_err_held got err/done=%b exp 10", {host_error, host_done});
      else pass_cnt++;
   endtask

   task automatic test_arbitration();
      int cyc;
      logic seen;
      sd_busy = 1'b1;
      host_req(1'b1, 1'b1, 26'h2ABCDE);
      chk_cnt++;
      if ({host_error, host_busy, sd_op_code} !== 3'b010)
         $display("FAIL arb_accept got err/busy/op=%b exp 010", {host_error, host_busy, sd_op_code});
      else pass_cnt++;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (sd_execute !== 1'b0) seen = 1'b1;
      end
      chk_cnt++;
      if (seen !== 1'b0) $display("FAIL arb_exec_while_busy got %b exp 0", seen); else pass_cnt++;
      sd_busy = 1'b0;
      wait_exec(cyc);
      chk_cnt++;
      if (cyc !== 1) $display("FAIL arb_exec_after_busy got %0d exp 1", cyc); else pass_cnt++;
      chk_cnt++;
      if (sd_sector_address !== 26'h2ABCDE)
         $display("FAIL arb_sector got %h exp 2abcde", sd_sector_address);
      else pass_cnt++;
      tick();
      run_bytes(512, M_RD_PUSH, 8'h5A);
      tick();
      sd_finished_sector = 1'b1;
      tick();
      sd_finished_sector = 1'b0;
      chk_cnt++;
      if ({host_done, host_error, host_busy} !== 3'b100)
         $display("FAIL arb_done got done/err/busy=%b exp 100", {host_done, host_error, host_busy});
      else pass_cnt++;
      readback_all("arb_ram");
   endtask

   task automatic test_reset_mid_xfer();
      int cyc;
      host_req(1'b0, 1'b1, 26'h0000777);
      wait_exec(cyc);
      tick();
      run_bytes(100, M_WR_QUIET, 8'h00);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk_cnt++;
      if ({host_rdata, host_busy, host_done, host_error, sd_op_code, sd_execute,
           sd_sector_address, sd_outgoing_byte} !== 48'd0)
         $display("FAIL midreset_outputs got %h exp 0",
                  {host_rdata, host_busy, host_done, host_error, sd_op_code, sd_execute,
                   sd_sector_address, sd_outgoing_byte});
      else pass_cnt++;
      host_req(1'b1, 1'b0, 26'h0000001);
      chk_cnt++;
      if (host_busy !== 1'b1) $display("FAIL midreset_reaccept got %b exp 1", host_busy); else pass_cnt++;
      wait_exec(cyc);
      chk_cnt++;
      if (cyc !== 1) $display("FAIL midreset_exec got %0d exp 1", cyc); else pass_cnt++;
      tick();
      run_bytes(512, M_RD_QUIET, 8'h11);
      tick();
      sd_finished_sector = 1'b1;
      tick();
      sd_finished_sector = 1'b0;
      chk_cnt++;
      if ({host_done, host_error, host_busy} !== 3'b100)
         $display("FAIL midreset_done got done/err/busy=%b exp 100", {host_done, host_error, host_busy});
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_read();
      test_write();
      test_short_sector();
      test_timeout();
      test_arbitration();
      test_reset_mid_xfer();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog simulation did not complete, %0d/%0d so far", pass_cnt, chk_cnt);
      $fatal(1);
   end

endmodule

// File: doc/sd_sector_buffer.md
# sd_sector_buffer

Sector-level front end sitting directly upstream of the SD card controller. Holds one 512-byte sector in an internal dual-port RAM and translates a single host read or write request into one controller operation. It drives the controller's op code, execute strobe and sector address, feeds outgoing bytes on a write, captures incoming bytes on a read, and reports completion or error back to the host.

## Interface
- TIMEOUT_CYCLES, default 1000000: maximum `clk` cycles allowed between execute and the first byte strobe, and between consecutive strobes; must be ≥ 1.
- clk  in  1  master clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- host_rd_req  in  1  one-cycle request: read `host_sector` from the card into the buffer.
- host_wr_req  in  1  one-cycle request: write the buffer to `host_sector` on the card.
- host_sector  in  26  sector address; sampled on the request cycle.
- host_addr  in  9  buffer byte address for host access.
- host_we  in  1  host buffer write enable.
- host_wdata  in  8  host buffer write data.
- host_rdata  out  8  buffer byte at `host_addr`, registered.
- host_busy  out  1  operation in progress.
- host_done  out  1  one-cycle completion strobe.
- host_error  out  1  last operation failed; held until the next accepted request.
- sd_op_code  out  1  0 = READ, 1 = WRITE; drives the controller op code.
- sd_execute  out  1  one-cycle start strobe to the controller.
- sd_sector_address  out  26  sector address to the controller.
- sd_outgoing_byte  out  8  byte to write.
- sd_incoming_byte  in  8  byte read.
- sd_finished_byte  in  1  one-cycle byte-done strobe.
- sd_finished_sector  in  1  one-cycle operation-done strobe.
- sd_busy  in  1  controller busy.

## Operation
- Reset values:
  - all outputs 0;
  - state IDLE; byte counter and timer 0;
  - RAM contents are not cleared.
- IDLE:
  - `host_busy` = 0.
  - `host_we` writes `host_wdata` into RAM[`host_addr`].
  - If a request is present, latch `host_sector` into `sd_sector_address`, set `sd_op_code`, clear `host_error`, set `host_busy`, and go to WAIT_READY.
  - If read and write requests arrive in the same cycle, the read wins; the write request is dropped.
- WAIT_READY: stay while `sd_busy` = 1. When `sd_busy` = 0, go to ISSUE.
- ISSUE:
  - `sd_execute` = 1 for exactly this cycle.
  - Byte counter = 0; timer = 0.
  - Go to XFER.
- XFER:
  - Write op: `sd_outgoing_byte` = RAM[counter], registered; it is updated the cycle after the counter changes.
  - Read op: on `sd_finished_byte`, write `sd_incoming_byte` into RAM[counter].
  - Both ops: each `sd_finished_byte` increments the counter (10-bit) and clears the timer.
  - On `sd_finished_sector`:
    - counter == 512 → DONE;
    - otherwise → ERR.
  - A `sd_finished_byte` while counter == 512 → ERR (overrun); no RAM write.
  - Timer reaches TIMEOUT_CYCLES → ERR.
  - If `sd_finished_byte` and `sd_finished_sector` arrive in the same cycle, the byte is processed first; the sector check uses the incremented count.
- DONE: `host_done` = 1 for one cycle, `host_busy` → 0, go to IDLE.
- ERR: `host_done` = 1 and `host_error` = 1 for one cycle, `host_busy` → 0, go to IDLE. `host_error` then stays 1.
- Host access while busy:
  - `host_we` is ignored; RAM is not modified by the host.
  - `host_rd_req` / `host_wr_req` are ignored; no queueing.
  - `host_rdata` remains readable; contents are undefined until `host_done`.
- `rst_n` low mid-operation: return to IDLE next edge and drop `sd_execute`. The controller is not informed; the host must re-request after `sd_busy` falls.

## Timing
- Request to `sd_execute`: 2 cycles minimum (request edge → WAIT_READY → ISSUE), plus any cycles spent waiting on `sd_busy`.
- `host_rdata` latency: 1 cycle from `host_addr`.
- Write-op `sd_outgoing_byte` is valid 2 cycles after `sd_execute` for byte 0, and 2 cycles after each `sd_finished_byte` for the next byte. The controller consumes a byte no sooner than 8 SPI clocks later.
- `host_done` asserts 1 cycle after `sd_finished_sector`, on the same edge `host_busy` falls.
- Timeout: ERR is entered exactly TIMEOUT_CYCLES cycles after the last execute or byte strobe.

## Test plan
- Read: preload nothing, pulse `host_rd_req` with sector 26'h12345. Require:
  - `sd_op_code` = 0, `sd_sector_address` = 26'h12345, one `sd_execute` pulse.
  - The model returns bytes `i[7:0]` for i = 0..511 then `sd_finished_sector`.
  - `host_done` with `host_error` = 0; `host_addr` 9'h1FF reads 8'hFF.
- Write: host fills RAM[i] = ~i[7:0], pulses `host_wr_req`. Require:
  - `sd_op_code` = 1.
  - The model captures `sd_outgoing_byte` on each `sd_finished_byte` and sees sequence 8'hFF, 8'hFE, …; 512 bytes total.
  - Clean `host_done`.
- Short sector: the model sends 300 byte strobes, then `sd_finished_sector`. Require `host_done` = 1, `host_error` = 1, `host_busy` = 0.
- Timeout with TIMEOUT_CYCLES = 50: the model never strobes after `sd_execute`. Require ERR exactly 50 cycles after `sd_execute`, and `host_error` held until the next request.
- Arbitration:
  - `sd_busy` held 1 for 20 cycles: `sd_execute` must fire only after it drops.
  - Read and write requests in the same cycle: a read is performed.
  - `host_we` during busy leaves RAM unchanged.
- Reset mid-XFER at byte 100: `rst_n` low for one cycle. Require all outputs 0 next cycle, and a new request is accepted afterward.
